// File: rtl/smpl_capture.sv
// rtl/smpl_capture.sv - circular sample-RAM capture controller with pre/post trigger sequencing
//
// Ports:
//   clk, rst_n      clock and synchronous active-low reset
//   smpl, smpl_en   packed sample word and its one-clk strobe
//   run, abort      one-clk start / abort pulses (abort has priority)
//   trig            one-clk trigger event
//   trig_pos        number of post-trigger words, latched when run is accepted
//   we/waddr/wdata  registered RAM write port
//   armed, triggered, capture_done   status flags
//   trig_addr       address of the first post-trigger word
//   oldest_addr     write pointer; the oldest buffered word once DONE
module smpl_capture #(
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        smpl,
    input  logic              smpl_en,
    input  logic              run,
    input  logic              abort,
    input  logic              trig,
    input  logic [ADDR_W-1:0] trig_pos,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [7:0]        wdata,
    output logic              armed,
    output logic              triggered,
    output logic              capture_done,
    output logic [ADDR_W-1:0] trig_addr,
    output logic [ADDR_W-1:0] oldest_addr
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_ARMED,
        S_POST,
        S_DONE
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] wptr;
    logic [ADDR_W-1:0] pre_cnt;
    logic [ADDR_W-1:0] post_cnt;
    logic [ADDR_W-1:0] trig_pos_l;
    logic [ADDR_W-1:0] pre_inc;
    logic [ADDR_W-1:0] post_inc;
    logic [ADDR_W-1:0] pre_target;
    logic              start;
    logic              wr;
    logic              take_trig;

    assign pre_inc  = pre_cnt + ADDR_W'(1);
    assign post_inc = post_cnt + ADDR_W'(1);
    // ENTRIES - trig_pos_l; trig_pos_l is never 0, so the modulo result is exact.
    assign pre_target = ADDR_W'(0) - trig_pos_l;

    assign armed        = (state == S_ARMED);
    assign capture_done = (state == S_DONE);
    assign oldest_addr  = wptr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        wr        = 1'b0;
        take_trig = 1'b0;
        if (abort) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (run) begin
                        start     = 1'b1;
                        state_nxt = S_PRE;
                    end
                end
                S_PRE: begin
                    if (smpl_en) begin
                        wr = 1'b1;
                        if (pre_inc == pre_target) begin
                            state_nxt = S_ARMED;
                        end
                    end
                end
                S_ARMED: begin
                    wr = smpl_en;
                    if (trig) begin
                        take_trig = 1'b1;
                        // A coincident word is post word 1 and may already finish the capture.
                        if (smpl_en && (trig_pos_l == ADDR_W'(1))) begin
                            state_nxt = S_DONE;
                        end else begin
                            state_nxt = S_POST;
                        end
                    end
                end
                S_POST: begin
                    if (smpl_en) begin
                        wr = 1'b1;
                        if (post_inc == trig_pos_l) begin
                            state_nxt = S_DONE;
                        end
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr       <= '0;
            pre_cnt    <= '0;
            post_cnt   <= '0;
            trig_pos_l <= ADDR_W'(1);
            we         <= 1'b0;
            waddr      <= '0;
            wdata      <= '0;
            trig_addr  <= '0;
            triggered  <= 1'b0;
        end else begin
            we <= wr;
            if (wr) begin
                waddr <= wptr;
                wdata <= smpl;
                wptr  <= wptr + ADDR_W'(1);
            end
            if (start) begin
                wptr       <= '0;
                pre_cnt    <= '0;
                post_cnt   <= '0;
                triggered  <= 1'b0;
                trig_pos_l <= (trig_pos == '0) ? ADDR_W'(1) : trig_pos;
            end
            if (wr && (state == S_PRE)) begin
                pre_cnt <= pre_inc;
            end
            if (take_trig) begin
                triggered <= 1'b1;
                trig_addr <= wptr;
                post_cnt  <= smpl_en ? ADDR_W'(1) : '0;
            end else if (wr && (state == S_POST)) begin
                post_cnt <= post_inc;
            end
            if (abort) begin
                triggered <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_smpl_capture.sv
// tb/tb_smpl_capture.sv - self-checking bench for smpl_capture (ADDR_W=4)
module tb_smpl_capture;

    localparam int AW      = 4;
    localparam int ENTRIES = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [7:0]    smpl = '0;
    logic          smpl_en = 1'b0;
    logic          run = 1'b0;
    logic          abort = 1'b0;
    logic          trig = 1'b0;
    logic [AW-1:0] trig_pos = '0;
    logic          we;
    logic [AW-1:0] waddr;
    logic [7:0]    wdata;
    logic          armed;
    logic          triggered;
    logic          capture_done;
    logic [AW-1:0] trig_addr;
    logic [AW-1:0] oldest_addr;

    smpl_capture #(.ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .smpl(smpl), .smpl_en(smpl_en), .run(run),
        .abort(abort), .trig(trig), .trig_pos(trig_pos), .we(we), .waddr(waddr),
        .wdata(wdata), .armed(armed), .triggered(triggered),
        .capture_done(capture_done), .trig_addr(trig_addr), .oldest_addr(oldest_addr)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int we_cnt  = 0;
    bit model_on = 1'b0;
    logic [7:0] dram [ENTRIES];

    // Reference model: capture phase tracked by write counts and flags.
    bit m_active, m_armed, m_trig, m_done;
    int m_wptr, m_trig_addr, m_nwr, m_npost, m_tp;
    bit e_we;
    int e_waddr, e_wdata;

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_step();
        e_we = 1'b0;
        if (!rst_n) begin
            m_active = 0; m_armed = 0; m_trig = 0; m_done = 0;
            m_wptr = 0; m_trig_addr = 0; m_nwr = 0; m_npost = 0; m_tp = 1;
            return;
        end
        if (abort) begin
            m_active = 0; m_armed = 0; m_trig = 0; m_done = 0;
            return;
        end
        if (!m_active) begin
            if (run) begin
                m_active = 1; m_armed = 0; m_trig = 0; m_done = 0;
                m_wptr = 0; m_nwr = 0; m_npost = 0;
                m_tp = (trig_pos == 0) ? 1 : int'(trig_pos);
            end
            return;
        end
        if (m_armed && trig) begin
            m_armed = 0;
            m_trig = 1;
            m_trig_addr = m_wptr;
        end
        if (smpl_en) begin
            e_we = 1'b1;
            e_waddr = m_wptr;
            e_wdata = int'(smpl);
            m_wptr = (m_wptr + 1) % ENTRIES;
            m_nwr++;
            if (m_trig) m_npost++;
            else if (m_nwr == ENTRIES - m_tp) m_armed = 1;
            if (m_trig && m_npost == m_tp) begin
                m_active = 0;
                m_done = 1;
            end
        end
    endtask

    task automatic check_model();
        chk("m_we", int'(we), int'(e_we));
        if (e_we) begin
            chk("m_waddr", int'(waddr), e_waddr);
            chk("m_wdata", int'(wdata), e_wdata);
        end
        chk("m_armed", int'(armed), int'(m_armed));
        chk("m_triggered", int'(triggered), int'(m_trig));
        chk("m_done", int'(capture_done), int'(m_done));
        chk("m_oldest", int'(oldest_addr), m_wptr);
        chk("m_trig_addr", int'(trig_addr), m_trig_addr);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        if (we) begin
            dram[waddr] = wdata;
            we_cnt++;
        end
        if (model_on) check_model();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic start(input int tp);
        trig_pos = AW'(tp);
        run = 1'b1;
        tick();
        run = 1'b0;
    endtask

    task automatic wr_word(input int v, input int gap);
        smpl_en = 1'b1;
        smpl = 8'(v);
        tick();
        smpl_en = 1'b0;
        for (int g = 0; g < gap; g++) tick();
    endtask

    task automatic pulse_trig();
        trig = 1'b1;
        tick();
        trig = 1'b0;
    endtask

    typedef struct {
        logic          rst_n, run, abort, trig, smpl_en;
        logic [7:0]    smpl;
        logic [AW-1:0] tp;
        logic          x_we;
        logic [AW-1:0] x_waddr;
        logic [7:0]    x_wdata;
        logic          x_armed, x_trig, x_done;
        logic [AW-1:0] x_oldest;
    } vec_t;

    vec_t vec [11];

    initial begin
        //            rst run ab trg en smpl   tp   we waddr wdata  arm trg dn old
        vec[0]  = '{1'b0,1'b0,1'b0,1'b1,1'b1,8'h11,4'd0, 1'b0,4'd0,8'h00, 1'b0,1'b0,1'b0,4'd0};
        vec[1]  = '{1'b0,1'b0,1'b0,1'b1,1'b0,8'h22,4'd0, 1'b0,4'd0,8'h00, 1'b0,1'b0,1'b0,4'd0};
        vec[2]  = '{1'b1,1'b0,1'b0,1'b0,1'b1,8'h33,4'd0, 1'b0,4'd0,8'h00, 1'b0,1'b0,1'b0,4'd0};
        vec[3]  = '{1'b1,1'b1,1'b1,1'b0,1'b0,8'h00,4'd3, 1'b0,4'd0,8'h00, 1'b0,1'b0,1'b0,4'd0};
        vec[4]  = '{1'b1,1'b1,1'b0,1'b0,1'b0,8'h00,4'd0, 1'b0,4'd0,8'h00, 1'b0,1'b0,1'b0,4'd0};
        vec[5]  = '{1'b1,1'b0,1'b0,1'b0,1'b1,8'hAA,4'd0, 1'b1,4'd0,8'hAA, 1'b0,1'b0,1'b0,4'd1};
        vec[6]  = '{1'b1,1'b1,1'b0,1'b0,1'b0,8'h00,4'd7, 1'b0,4'd0,8'h00, 1'b0,1'b0,1'b0,4'd1};
        vec[7]  = '{1'b1,1'b0,1'b0,1'b1,1'b1,8'hBB,4'd0, 1'b1,4'd1,8'hBB, 1'b0,1'b0,1'b0,4'd2};
        vec[8]  = '{1'b1,1'b0,1'b1,1'b0,1'b1,8'hCC,4'd0, 1'b0,4'd0,8'h00, 1'b0,1'b0,1'b0,4'd2};
        vec[9]  = '{1'b1,1'b0,1'b0,1'b0,1'b1,8'hDD,4'd0, 1'b0,4'd0,8'h00, 1'b0,1'b0,1'b0,4'd2};
        vec[10] = '{1'b1,1'b1,1'b0,1'b0,1'b0,8'h00,4'd5, 1'b0,4'd0,8'h00, 1'b0,1'b0,1'b0,4'd0};

        for (int i = 0; i < 11; i++) begin
            rst_n = vec[i].rst_n; run = vec[i].run; abort = vec[i].abort;
            trig = vec[i].trig; smpl_en = vec[i].smpl_en; smpl = vec[i].smpl;
            trig_pos = vec[i].tp;
            tick();
            chk($sformatf("v%0d_we", i), int'(we), int'(vec[i].x_we));
            if (vec[i].x_we) begin
                chk($sformatf("v%0d_waddr", i), int'(waddr), int'(vec[i].x_waddr));
                chk($sformatf("v%0d_wdata", i), int'(wdata), int'(vec[i].x_wdata));
            end
            chk($sformatf("v%0d_armed", i), int'(armed), int'(vec[i].x_armed));
            chk($sformatf("v%0d_trig", i), int'(triggered), int'(vec[i].x_trig));
            chk($sformatf("v%0d_done", i), int'(capture_done), int'(vec[i].x_done));
            chk($sformatf("v%0d_oldest", i), int'(oldest_addr), int'(vec[i].x_oldest));
            chk($sformatf("v%0d_taddr", i), int'(trig_addr), 0);
        end
        run = 0; abort = 0; trig = 0; smpl_en = 0;
        model_on = 1'b1;

        // Basic capture, trig_pos=4, strobe every 4 clk.
        do_reset();
        we_cnt = 0;
        start(4);
        for (int i = 0; i < 20; i++) begin
            wr_word(i, 3);
            if (i == 10) chk("basic_armed_11", int'(armed), 0);
            if (i == 11) chk("basic_armed_12", int'(armed), 1);
        end
        pulse_trig();
        chk("basic_triggered", int'(triggered), 1);
        chk("basic_trig_addr", int'(trig_addr), 4);
        for (int i = 20; i < 24; i++) wr_word(i, 3);
        for (int a = 4; a < 8; a++) chk($sformatf("basic_ram%0d", a), int'(dram[a]), a + 16);
        chk("basic_done", int'(capture_done), 1);
        chk("basic_oldest", int'(oldest_addr), 8);
        chk("basic_we_cnt", we_cnt, 24);

        // Early trigger in PRE is ignored.
        start(4);
        for (int i = 0; i < 3; i++) wr_word(8'h30 + i, 0);
        pulse_trig();
        chk("early_ignored", int'(triggered), 0);
        for (int i = 3; i < 14; i++) wr_word(8'h30 + i, 0);
        pulse_trig();
        chk("early_trig_addr", int'(trig_addr), 14);
        for (int i = 0; i < 4; i++) wr_word(8'h40 + i, 1);
        chk("early_ram14", int'(dram[14]), 8'h40);
        chk("early_ram15", int'(dram[15]), 8'h41);
        chk("early_ram0", int'(dram[0]), 8'h42);
        chk("early_ram1", int'(dram[1]), 8'h43);
        chk("early_oldest", int'(oldest_addr), 2);

        // Coincident trig+smpl_en in ARMED at wptr=13, trig_pos=2.
        start(2);
        for (int i = 0; i < 29; i++) wr_word(i, 0);
        chk("coin_armed", int'(armed), 1);
        chk("coin_wptr", int'(oldest_addr), 13);
        smpl_en = 1; trig = 1; smpl = 8'hC3;
        tick();
        smpl_en = 0; trig = 0;
        chk("coin_we", int'(we), 1);
        chk("coin_waddr", int'(waddr), 13);
        chk("coin_trig_addr", int'(trig_addr), 13);
        chk("coin_not_done", int'(capture_done), 0);
        wr_word(8'hC4, 0);
        chk("coin_ram14", int'(dram[14]), 8'hC4);
        chk("coin_done", int'(capture_done), 1);
        chk("coin_oldest", int'(oldest_addr), 15);

        // trig_pos=0 behaves as 1.
        start(0);
        for (int i = 0; i < 14; i++) wr_word(i, 0);
        chk("tp0_armed_14", int'(armed), 0);
        wr_word(14, 0);
        chk("tp0_armed_15", int'(armed), 1);
        pulse_trig();
        we_cnt = 0;
        wr_word(8'h77, 0);
        chk("tp0_done", int'(capture_done), 1);
        wr_word(8'h78, 0);
        chk("tp0_one_write", we_cnt, 1);

        // run ignored in ARMED, abort in POST.
        start(3);
        for (int i = 0; i < 13; i++) wr_word(i, 0);
        run = 1; tick(); run = 0;
        chk("run_ignored_wptr", int'(oldest_addr), 13);
        chk("run_ignored_armed", int'(armed), 1);
        pulse_trig();
        wr_word(8'h55, 0);
        abort = 1; smpl_en = 1; tick(); abort = 0; smpl_en = 0;
        chk("abort_triggered", int'(triggered), 0);
        chk("abort_we", int'(we), 0);
        we_cnt = 0;
        wr_word(1, 0);
        wr_word(2, 0);
        chk("abort_no_we", we_cnt, 0);

        // run+abort in DONE -> IDLE.
        start(1);
        for (int i = 0; i < 15; i++) wr_word(i, 0);
        pulse_trig();
        wr_word(8'h99, 0);
        chk("ra_done", int'(capture_done), 1);
        run = 1; abort = 1; tick(); run = 0; abort = 0;
        chk("ra_cleared", int'(capture_done), 0);
        we_cnt = 0;
        wr_word(3, 0);
        chk("ra_idle_no_we", we_cnt, 0);

        // Randomized stimulus against the model.
        for (int c = 0; c < 5000; c++) begin
            rst_n    = ($urandom_range(0, 999) != 0);
            run      = ($urandom_range(0, 29) == 0);
            abort    = ($urandom_range(0, 249) == 0);
            trig     = ($urandom_range(0, 9) == 0);
            smpl_en  = ($urandom_range(0, 1) == 1);
            smpl     = 8'($urandom);
            trig_pos = AW'($urandom_range(0, ENTRIES - 1));
            tick();
        end
        rst_n = 1; run = 0; abort = 0; trig = 0; smpl_en = 0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/smpl_capture.md
# smpl_capture

Capture controller directly downstream of the channel sampler. Consumes the packed 8-bit sample word, which holds four consecutive CH_H/CH_L sample pairs, on each word strobe. Writes the words into a circular sample RAM and runs the pre-trigger, armed and post-trigger sequence. Reports the trigger address and oldest-word pointer so the readout logic can unroll the buffer.

## Interface
- ADDR_W, 9, RAM address width; buffer depth ENTRIES = 2^ADDR_W words
- clk  in  1  system clock, all logic on posedge
- rst_n  in  1  synchronous active-low reset
- smpl  in  8  packed sample word from channel sampler
- smpl_en  in  1  one-clk strobe: smpl holds a new word this cycle
- run  in  1  one-clk start pulse
- abort  in  1  one-clk abort pulse
- trig  in  1  one-clk trigger event from trigger logic
- trig_pos  in  ADDR_W  number of post-trigger words; sampled on accepted run
- we  out  1  RAM write enable (registered)
- waddr  out  ADDR_W  RAM write address (registered)
- wdata  out  8  RAM write data (registered)
- armed  out  1  high in ARMED state
- triggered  out  1  high from accepted trigger until next run, abort or reset
- capture_done  out  1  high in DONE
- trig_addr  out  ADDR_W  address of first post-trigger word
- oldest_addr  out  ADDR_W  current write pointer; in DONE, address of the oldest word

## Operation
- States: IDLE, PRE, ARMED, POST, DONE.
- Reset (rst_n=0 at posedge) forces IDLE. Reset values: wptr, pre_cnt, post_cnt, we, waddr, wdata, trig_addr all 0. armed, triggered, capture_done all 0.
- run accepted only in IDLE or DONE, and only when abort is low.
  - On acceptance: wptr=0, counters=0, triggered=0, state=PRE.
  - trig_pos_l latched; trig_pos_l = 1 when trig_pos=0.
  - run in PRE, ARMED or POST is ignored.
- Write rule: in PRE, ARMED or POST, a cycle with smpl_en=1 writes one word.
  - Next cycle: we=1, waddr=wptr, wdata=smpl.
  - wptr increments modulo ENTRIES (wraps 2^ADDR_W-1 -> 0).
  - smpl_en in IDLE or DONE produces no write.
- PRE: pre_cnt counts writes. Reaching ENTRIES - trig_pos_l moves to ARMED on that same write. trig is ignored in PRE.
- ARMED: writes continue circularly. trig=1 moves to POST, sets triggered=1 and trig_addr=wptr.
  - trig and smpl_en in the same cycle: that word is written at trig_addr and counts as post word 1.
- POST: post_cnt counts writes, including a coincident trigger-cycle write. Reaching trig_pos_l moves to DONE. trig is ignored.
- DONE: no writes. capture_done=1. oldest_addr = wptr = trig_addr + trig_pos_l mod ENTRIES.
- abort in any state moves to IDLE and clears armed, triggered and capture_done. No write is issued for a coincident smpl_en. wptr and trig_addr hold.
- abort and run in the same cycle: abort wins.

## Timing
- Write latency: 1 clk from smpl_en edge to we/waddr/wdata.
- we is high for exactly 1 clk per accepted word.
- armed, triggered and capture_done change on the clk edge ending the cycle that caused the transition.
- oldest_addr is combinational from wptr and updates with each write.
- smpl_en gaps are arbitrary, minimum 1 clk. Back-to-back strobes give one write per clk.

## Test plan
- Reset: assert rst_n=0 for 2 clk with smpl_en and trig toggling -> all outputs 0, state IDLE, no we.
- Basic capture (ADDR_W=4, trig_pos=4), smpl_en every 4 clk, smpl=0x00,0x01,...:
  - armed rises after the 12th write.
  - trig after 20 writes -> trig_addr=4 (wrapped).
  - Post words 0x14..0x17 land at addr 4..7.
  - capture_done=1, oldest_addr=8, exactly 24 we pulses.
- Early trigger: trig during PRE, then again in ARMED after 14 writes:
  - first trig ignored (triggered stays 0).
  - trig_addr=14; post words go to 14, 15, 0, 1.
- Coincident trig+smpl_en in ARMED at wptr=13, trig_pos=2:
  - word written at 13 with trig_addr=13.
  - one more write at 14, then DONE, oldest_addr=15.
- trig_pos=0:
  - armed after 15 writes.
  - after trigger, exactly one post write, then DONE.
- Abort and run rules:
  - abort in POST -> next clk IDLE, triggered=0, no further we.
  - run during ARMED ignored (wptr not reset).
  - run+abort in DONE -> IDLE.
